// File: rtl/wb_stream_pkg.sv
// Shared types and constants for the Wishbone stream writer.
// The READ state only exists when WB_STREAM_READBACK_EN is defined.
package wb_stream_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
`ifdef WB_STREAM_READBACK_EN
    READ   = 2'd2,
`endif
    FINISH = 2'd3
  } state_t;

  // Byte address of a word index relative to a 4-byte aligned base.
  function automatic logic [31:0] wordAdr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone classic bus bundle; clock and reset travel with the bus.
interface wshb_if (
  input logic clk,
  input logic rst
);

  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        we;
  logic        stb;
  logic        cyc;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    input  clk, rst, dat_sm, ack, err, rty,
    output adr, dat_ms, we, stb, cyc, sel, cti, bte
  );

  modport slave (
    input  clk, rst, adr, dat_ms, we, stb, cyc, sel, cti, bte,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with a combinational head output.
// clr empties the FIFO like reset does, without touching storage.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign dout     = r_mem[r_rdPtr];
  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= din;
  end

endmodule

// File: rtl/wb_stream_writer.sv
// Buffers a 32-bit stream and writes it to consecutive Wishbone words.
// Define WB_STREAM_READBACK_EN to read back and verify every written word.
module wb_stream_writer
  import wb_stream_pkg::*;
#(
  parameter logic [31:0] ADR_BASE   = 32'h0000_0000,
  parameter int          NWORDS     = 2048,
  parameter int          FIFO_DEPTH = 4
) (
  wshb_if.master      wb_m,
  input  logic        start,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        busy,
  output logic        done,
  output logic        bus_err,
  output logic [15:0] word_cnt
`ifdef WB_STREAM_READBACK_EN
  ,
  output logic [15:0] rb_err_cnt
`endif
);

  localparam logic [15:0] NWORDS_W  = 16'(NWORDS);
  localparam logic [15:0] LAST_WORD = 16'(NWORDS - 1);

  state_t      r_state, w_stateNext;
  logic        r_cyc, r_stb, r_we, w_cycNext, w_stbNext, w_weNext;
  logic [31:0] r_adr, r_datMs, w_adrNext, w_datMsNext;
  logic [3:0]  r_sel, w_selNext;
  logic [15:0] r_wordCnt, w_wordCntNext, r_acceptCnt;
  logic        r_busErr, w_busErrNext;
  logic        w_fifoFull, w_fifoEmpty, w_push, w_pop, w_clr;
  logic [31:0] w_fifoHead;
  logic        w_ack, w_err, w_rty;
`ifdef WB_STREAM_READBACK_EN
  logic [15:0] r_rbErrCnt, w_rbErrCntNext;
  assign rb_err_cnt = r_rbErrCnt;
`else
  logic        w_unusedDatSm;
  assign w_unusedDatSm = ^wb_m.dat_sm;
`endif

  // Slave responses only count while a strobe is actually outstanding.
  assign w_ack   = r_stb && wb_m.ack;
  assign w_err   = r_stb && wb_m.err;
  assign w_rty   = r_stb && wb_m.rty;
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == FINISH);
  assign w_clr   = (r_state == IDLE) && start;
  assign s_ready = busy && !w_fifoFull && (r_acceptCnt < NWORDS_W);
  assign w_push  = s_valid && s_ready;

  assign wb_m.cyc    = r_cyc;
  assign wb_m.stb    = r_stb;
  assign wb_m.we     = r_we;
  assign wb_m.adr    = r_adr;
  assign wb_m.dat_ms = r_datMs;
  assign wb_m.sel    = r_sel;
  assign wb_m.cti    = CTI_CLASSIC;
  assign wb_m.bte    = BTE_LINEAR;
  assign bus_err     = r_busErr;
  assign word_cnt    = r_wordCnt;

  // Leftovers from an aborted transfer are discarded when a new one starts.
  stream_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (wb_m.clk),
    .rst  (wb_m.rst),
    .clr  (w_clr),
    .push (w_push),
    .pop  (w_pop),
    .din  (s_data),
    .dout (w_fifoHead),
    .full (w_fifoFull),
    .empty(w_fifoEmpty)
  );

  always_ff @(posedge wb_m.clk) begin
    if (wb_m.rst || w_clr) r_acceptCnt <= '0;
    else if (w_push)       r_acceptCnt <= r_acceptCnt + 16'd1;
  end

  // Every bus output is computed here and registered below, so a launched
  // access stays frozen until the slave answers it.
  always_comb begin
    w_stateNext   = r_state;
    w_cycNext     = r_cyc;
    w_stbNext     = r_stb;
    w_weNext      = r_we;
    w_adrNext     = r_adr;
    w_datMsNext   = r_datMs;
    w_selNext     = r_sel;
    w_wordCntNext = r_wordCnt;
    w_busErrNext  = r_busErr;
    w_pop         = 1'b0;
`ifdef WB_STREAM_READBACK_EN
    w_rbErrCntNext = r_rbErrCnt;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_stateNext   = WRITE;
          w_wordCntNext = '0;
          w_busErrNext  = 1'b0;
`ifdef WB_STREAM_READBACK_EN
          w_rbErrCntNext = '0;
`endif
        end
      end
      WRITE: begin
        if (w_err) begin
          w_busErrNext = 1'b1;
          w_cycNext    = 1'b0;
          w_stbNext    = 1'b0;
          w_stateNext  = FINISH;
        end else if (w_ack) begin
          w_pop         = 1'b1;
          w_wordCntNext = r_wordCnt + 16'd1;
`ifdef WB_STREAM_READBACK_EN
          w_weNext    = 1'b0;
          w_stateNext = READ;
`else
          w_cycNext = 1'b0;
          w_stbNext = 1'b0;
          if (r_wordCnt == LAST_WORD) w_stateNext = FINISH;
`endif
        end else if (w_rty) begin
          w_cycNext = 1'b0;
          w_stbNext = 1'b0;
        end else if (!r_stb && !w_fifoEmpty) begin
          w_cycNext   = 1'b1;
          w_stbNext   = 1'b1;
          w_weNext    = 1'b1;
          w_selNext   = 4'hF;
          w_adrNext   = wordAdr(ADR_BASE, r_wordCnt);
          w_datMsNext = w_fifoHead;
        end
      end
`ifdef WB_STREAM_READBACK_EN
      READ: begin
        if (w_err) begin
          w_busErrNext = 1'b1;
          w_cycNext    = 1'b0;
          w_stbNext    = 1'b0;
          w_stateNext  = FINISH;
        end else if (w_ack) begin
          w_cycNext = 1'b0;
          w_stbNext = 1'b0;
          if (wb_m.dat_sm != r_datMs) w_rbErrCntNext = satInc(r_rbErrCnt);
          w_stateNext = (r_wordCnt == NWORDS_W) ? FINISH : WRITE;
        end else if (w_rty) begin
          w_cycNext = 1'b0;
          w_stbNext = 1'b0;
        end else if (!r_stb) begin
          w_cycNext = 1'b1;
          w_stbNext = 1'b1;
        end
      end
`endif
      FINISH:  w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge wb_m.clk) begin
    if (wb_m.rst) begin
      r_state   <= IDLE;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_datMs   <= '0;
      r_sel     <= '0;
      r_wordCnt <= '0;
      r_busErr  <= 1'b0;
`ifdef WB_STREAM_READBACK_EN
      r_rbErrCnt <= '0;
`endif
    end else begin
      r_state   <= w_stateNext;
      r_cyc     <= w_cycNext;
      r_stb     <= w_stbNext;
      r_we      <= w_weNext;
      r_adr     <= w_adrNext;
      r_datMs   <= w_datMsNext;
      r_sel     <= w_selNext;
      r_wordCnt <= w_wordCntNext;
      r_busErr  <= w_busErrNext;
`ifdef WB_STREAM_READBACK_EN
      r_rbErrCnt <= w_rbErrCntNext;
`endif
    end
  end

endmodule

// File: tb/tb_wb_stream_writer.sv
// Directed-plus-random bench for wb_stream_writer with a reactive Wishbone slave.
// Expected writes are derived from the accepted stream words: word i goes to BASE+4*i.
module tb_wb_stream_writer;

  localparam int          NW   = 4;
  localparam int          FD   = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, busy, done, bus_err;
  logic [15:0] word_cnt;
`ifdef WB_STREAM_READBACK_EN
  logic [15:0] rb_err_cnt;
`endif

  always #5 clk = ~clk;

  wshb_if wb (.clk(clk), .rst(rst));

  wb_stream_writer #(.ADR_BASE(BASE), .NWORDS(NW), .FIFO_DEPTH(FD)) dut (
    .wb_m    (wb),
    .start   (start),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .busy    (busy),
    .done    (done),
    .bus_err (bus_err),
    .word_cnt(word_cnt)
`ifdef WB_STREAM_READBACK_EN
    ,
    .rb_err_cnt(rb_err_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // stream driver and its model of accepted words
  logic [31:0] streamQ[$];
  logic [31:0] acceptedQ[$];
  bit          gapMode = 1'b0;
  bit          gapTog = 1'b0;

  // slave behaviour knobs and observations
  int          waitLeft = -1;
  bit          slaveHold = 1'b0;
  int          holdWord = -1;
  int          errWord = -1;
  int          rtyWord = -1;
  int          rtyCount = 0;
  int          rtyPhase = 0;
  logic [31:0] rtyAdr = '0, rtyDat = '0, reAdr = '0, reDat = '0;
  logic        gapStb = 1'b1, reStb = 1'b0;
  bit          spurArm = 1'b0;
  int          badReadWord = -1;
  int          readCount = 0;
  int          slvIdx;
  logic [31:0] slaveMem [16];

  // monitor
  logic [31:0] wrAdrQ[$];
  logic [31:0] wrDatQ[$];
  logic [8:0]  wrCtlQ[$];
  int          doneCount = 0;
  int          stbEmptyViol = 0;
  int          pushTot = 0, popTot = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] words[$], input bit gap);
    wrAdrQ.delete();
    wrDatQ.delete();
    wrCtlQ.delete();
    acceptedQ.delete();
    streamQ = words;
    gapMode = gap;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      step(1);
    end
    checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic checkWrites(input string tag);
    checkOutput({tag, "_nwrites"}, 64'(wrAdrQ.size()), 64'(NW));
    for (int i = 0; i < wrAdrQ.size() && i < acceptedQ.size(); i++) begin
      checkOutput($sformatf("%s_w%0d", tag, i), {wrAdrQ[i], wrDatQ[i]},
                  {BASE + 32'(4 * i), acceptedQ[i]});
      checkOutput($sformatf("%s_ctl%0d", tag, i), 64'(wrCtlQ[i]), 64'({4'hF, 3'b000, 2'b00}));
    end
  endtask

  task automatic randWords(output logic [31:0] q[$]);
    q.delete();
    for (int i = 0; i < NW; i++) q.push_back($urandom);
  endtask

  // Stream driver: offers the queue head, gapped every other cycle when asked.
  initial begin
    forever begin
      @(negedge clk);
      if (streamQ.size() > 0 && (!gapMode || gapTog)) begin
        s_valid = 1'b1;
        s_data  = streamQ[0];
        if (s_ready && !rst) acceptedQ.push_back(streamQ.pop_front());
      end else begin
        s_valid = 1'b0;
      end
      gapTog = !gapTog;
    end
  end

  // Reactive slave: random wait states, scripted err/rty/hold, memory for reads.
  initial begin
    wb.ack = 1'b0;
    wb.err = 1'b0;
    wb.rty = 1'b0;
    wb.dat_sm = '0;
    forever begin
      @(negedge clk);
      wb.ack = 1'b0;
      wb.err = 1'b0;
      wb.rty = 1'b0;
      if (rtyPhase == 1) begin
        gapStb = wb.stb;
        rtyPhase = 2;
      end else if (rtyPhase == 2) begin
        reStb = wb.stb;
        reAdr = wb.adr;
        reDat = wb.dat_ms;
        rtyPhase = 3;
      end
      if (wb.cyc && wb.stb && !rst) begin
        slvIdx = int'(wb.adr[5:2]);
        if (waitLeft < 0) waitLeft = $urandom_range(0, 2);
        if (!slaveHold && !(wb.we && slvIdx == holdWord) && waitLeft == 0) begin
          waitLeft = -1;
          if (wb.we && slvIdx == errWord) begin
            wb.err = 1'b1;
            errWord = -1;
          end else if (wb.we && slvIdx == rtyWord) begin
            wb.rty = 1'b1;
            rtyWord = -1;
            rtyCount++;
            rtyAdr = wb.adr;
            rtyDat = wb.dat_ms;
            rtyPhase = 1;
          end else begin
            wb.ack = 1'b1;
            if (!wb.we) begin
              readCount++;
              wb.dat_sm = (slvIdx == badReadWord) ? 32'hDEAD : slaveMem[slvIdx];
              if (slvIdx == badReadWord) badReadWord = -1;
            end
          end
        end else if (waitLeft > 0) begin
          waitLeft--;
        end
      end else begin
        waitLeft = -1;
        if (spurArm && busy && !wb.stb) begin
          wb.ack = 1'b1;
          spurArm = 1'b0;
        end
      end
    end
  end

  // Monitor: logs completed writes, counts done cycles, models FIFO occupancy.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (done) doneCount++;
      if (wb.stb && wb.we && pushTot == popTot) stbEmptyViol++;
      if (rst) begin
        pushTot = 0;
        popTot = 0;
      end else begin
        if (s_valid && s_ready) pushTot++;
        if (wb.cyc && wb.stb && wb.we && wb.ack) begin
          popTot++;
          wrAdrQ.push_back(wb.adr);
          wrDatQ.push_back(wb.dat_ms);
          wrCtlQ.push_back({wb.sel, wb.cti, wb.bte});
          slaveMem[int'(wb.adr[5:2])] = wb.dat_ms;
        end
      end
    end
  end

  initial begin
    logic [31:0] words[$];
    logic [31:0] none[$];
    int          doneBefore;
    int          readBefore;
    int          r;
    bit          reached;

    // reset state
    step(3);
    checkOutput("rst_ctrl", 64'({wb.cyc, wb.stb, wb.we, busy, done, bus_err, s_ready}), 64'd0);
    checkOutput("rst_wordcnt", 64'(word_cnt), 64'd0);
    checkOutput("rst_adr", 64'(wb.adr), 64'd0);
    checkOutput("rst_sel_dat", 64'({wb.sel, wb.dat_ms}), 64'd0);
`ifdef WB_STREAM_READBACK_EN
    checkOutput("rst_rberr", 64'(rb_err_cnt), 64'd0);
`endif
    rst = 1'b0;
    step(2);

    // basic transfer of the four fixed words
    words = '{32'h11, 32'h22, 32'h33, 32'h44};
    doneBefore = doneCount;
    readBefore = readCount;
    applyStimulus(words, 1'b0);
    waitIdle("basic", 300);
    checkWrites("basic");
    checkOutput("basic_done", 64'(doneCount - doneBefore), 64'd1);
    checkOutput("basic_wordcnt", 64'(word_cnt), 64'd4);
    checkOutput("basic_buserr", 64'(bus_err), 64'd0);
`ifdef WB_STREAM_READBACK_EN
    checkOutput("basic_reads", 64'(readCount - readBefore), 64'd4);
    checkOutput("basic_rberr", 64'(rb_err_cnt), 64'd0);
`endif

    // gapped stream, spurious ack with stb low, start while busy
    randWords(words);
    doneBefore = doneCount;
    stbEmptyViol = 0;
    spurArm = 1'b1;
    applyStimulus(words, 1'b1);
    step(3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    waitIdle("gap", 400);
    checkWrites("gap");
    checkOutput("gap_wordcnt", 64'(word_cnt), 64'd4);
    checkOutput("gap_stb_empty", 64'(stbEmptyViol), 64'd0);
    checkOutput("gap_done", 64'(doneCount - doneBefore), 64'd1);
    spurArm = 1'b0;

    // retry once on word 2
    randWords(words);
    rtyCount = 0;
    rtyPhase = 0;
    rtyWord = 2;
    applyStimulus(words, 1'b0);
    waitIdle("rty", 300);
    checkWrites("rty");
    checkOutput("rty_count", 64'(rtyCount), 64'd1);
    checkOutput("rty_first", {rtyAdr, rtyDat}, {BASE + 32'd8, acceptedQ[2]});
    checkOutput("rty_gap_stb", 64'(gapStb), 64'd0);
    checkOutput("rty_reissue", {31'd0, reStb, reAdr, reDat}, {31'd0, 1'b1, BASE + 32'd8, acceptedQ[2]});

    // bus error on word 1
    randWords(words);
    doneBefore = doneCount;
    errWord = 1;
    applyStimulus(words, 1'b0);
    waitIdle("err", 300);
    checkOutput("err_buserr", 64'(bus_err), 64'd1);
    checkOutput("err_wordcnt", 64'(word_cnt), 64'd1);
    checkOutput("err_done", 64'(doneCount - doneBefore), 64'd1);
    checkOutput("err_nwrites", 64'(wrAdrQ.size()), 64'd1);
    errWord = -1;
    streamQ.delete();
    start = 1'b1;
    step(1);
    start = 1'b0;
    checkOutput("err_clear_by_start", 64'(bus_err), 64'd0);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    streamQ.delete();
    acceptedQ.delete();
    step(2);

    // reset while the write of word 3 is outstanding
    randWords(words);
    holdWord = 3;
    applyStimulus(words, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (wb.stb && wb.adr == BASE + 32'd12) begin
        reached = 1'b1;
        break;
      end
      step(1);
    end
    checkOutput("rstmid_reach", 64'(reached), 64'd1);
    doneBefore = doneCount;
    rst = 1'b1;
    step(1);
    checkOutput("rstmid_ctrl", 64'({wb.cyc, wb.stb, busy, done}), 64'd0);
    checkOutput("rstmid_wordcnt", 64'(word_cnt), 64'd0);
    step(1);
    rst = 1'b0;
    holdWord = -1;
    streamQ.delete();
    step(2);
    checkOutput("rstmid_nodone", 64'(doneCount - doneBefore), 64'd0);
    applyStimulus(none, 1'b0);
    step(6);
    checkOutput("rstmid_fifo_empty", 64'({busy, wb.stb}), 64'({1'b1, 1'b0}));
    randWords(words);
    streamQ = words;
    waitIdle("postrst", 300);
    checkWrites("postrst");

    // FIFO fills while the slave stalls
    randWords(words);
    slaveHold = 1'b1;
    applyStimulus(words, 1'b0);
    step(10);
    checkOutput("full_accepted", 64'(acceptedQ.size()), 64'(FD));
    checkOutput("full_sready", 64'(s_ready), 64'd0);
    checkOutput("full_wordcnt", 64'(word_cnt), 64'd0);
    slaveHold = 1'b0;
    waitIdle("full", 300);
    checkWrites("full");

`ifdef WB_STREAM_READBACK_EN
    // corrupted readback of word 0
    randWords(words);
    badReadWord = 0;
    applyStimulus(words, 1'b0);
    waitIdle("rb", 400);
    checkOutput("rb_errcnt", 64'(rb_err_cnt), 64'd1);
    checkWrites("rb");
`endif

    // randomized transfers
    for (int k = 0; k < 3; k++) begin
      randWords(words);
      r = $urandom_range(0, 4);
      rtyWord = (r < 4) ? r : -1;
      doneBefore = doneCount;
      applyStimulus(words, 1'($urandom_range(0, 1)));
      waitIdle($sformatf("rnd%0d", k), 400);
      checkWrites($sformatf("rnd%0d", k));
      checkOutput($sformatf("rnd%0d_done", k), 64'(doneCount - doneBefore), 64'd1);
      checkOutput($sformatf("rnd%0d_wordcnt", k), 64'(word_cnt), 64'd4);
`ifdef WB_STREAM_READBACK_EN
      checkOutput($sformatf("rnd%0d_rberr", k), 64'(rb_err_cnt), 64'd0);
`endif
      rtyWord = -1;
    end

`ifndef WB_STREAM_READBACK_EN
    checkOutput("no_reads", 64'(readCount), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_stream_writer.md
WB_STREAM_WRITER -- requirements
Module: wb_stream_writer

Interface
REQ-001 Parameter ADR_BASE, default 32'h0000_0000, byte address of first word written; SHALL be 4-byte aligned.
REQ-002 Parameter NWORDS, default 2048, number of 32-bit words per transfer; range 1..65535.
REQ-003 Parameter FIFO_DEPTH, default 4, input FIFO depth; power of two, at least 2.
REQ-004 Port wb_m.clk  in  1  single clock, carried in the wshb_if interface; all logic on its rising edge.
REQ-005 Port wb_m.rst  in  1  synchronous reset, active-high, carried in the wshb_if interface.
REQ-006 Port wb_m  wshb_if.master  --  Wishbone master: adr, dat_ms, we, stb, cyc, sel, cti, bte out; dat_sm, ack, err, rty in.
REQ-007 Port start  in  1  one-cycle request to begin a transfer; honoured only in IDLE.
REQ-008 Port s_data  in  32  stream word.
REQ-009 Port s_valid  in  1  s_data is valid.
REQ-010 Port s_ready  out  1  block accepts s_data this cycle.
REQ-011 Port busy  out  1  high in every state except IDLE.
REQ-012 Port done  out  1  one-cycle pulse at the end of a transfer.
REQ-013 Port bus_err  out  1  sticky flag; set when wb_m.err is seen; cleared by start.
REQ-014 Port word_cnt  out  16  number of words acknowledged in the current transfer.

Function
REQ-015 States SHALL be IDLE, WRITE, READ (macro only), FINISH; start in IDLE SHALL clear word_cnt, the accept counter and bus_err, and SHALL move to WRITE.
REQ-016 A stream beat SHALL transfer on s_valid && s_ready; s_ready = busy && FIFO not full && accepted < NWORDS.
REQ-017 In WRITE with the FIFO non-empty, the block SHALL drive cyc=stb=we=1, sel=4'hF, cti=3'b000, bte=2'b00, adr=ADR_BASE+4*word_cnt, and dat_ms=FIFO head.
REQ-018 All Wishbone outputs SHALL be registered and held stable until ack, err or rty.
REQ-019 On write ack, the block SHALL pop the FIFO and increment word_cnt; the next write MAY follow back-to-back, with stb held high.
REQ-020 On rty, the block SHALL drop stb for one cycle and then repeat the identical access.
REQ-021 On err, the block SHALL set bus_err, drop cyc and stb, and go to FINISH.
REQ-022 When the ack for word NWORDS-1 completes, the block SHALL go to FINISH.
REQ-023 FINISH SHALL last one cycle with done=1, then return to IDLE.
REQ-024 cyc and stb SHALL be 0 in IDLE and FINISH, and whenever the FIFO is empty in WRITE.
REQ-025 An ack with stb low SHALL be ignored.
REQ-026 start asserted while busy SHALL be ignored.
REQ-027 A simultaneous push and pop on a full FIFO SHALL be impossible by construction, since s_ready is low when the FIFO is full.
REQ-028 A simultaneous push and pop on a non-empty FIFO SHALL keep the FIFO count unchanged.

Reset
REQ-029 On wb_m.rst the block SHALL enter IDLE, empty the FIFO, and drive cyc, stb, we, s_ready, busy, done and bus_err to 0.
REQ-030 On wb_m.rst, word_cnt and adr SHALL be 0, and sel and dat_ms SHALL be 0.
REQ-031 Reset asserted mid-access SHALL abandon the access immediately, with no completion pulse.

Configuration
REQ-032 The macro WB_STREAM_READBACK_EN, when defined, SHALL add a READ state and a 16-bit output rb_err_cnt.
REQ-033 With WB_STREAM_READBACK_EN, each write ack SHALL be followed by a read of the same adr (we=0).
REQ-034 With WB_STREAM_READBACK_EN, stb SHALL deassert in the cycle after the read ack, and dat_sm SHALL be compared with the written word at ack.
REQ-035 With WB_STREAM_READBACK_EN, each mismatch SHALL increment rb_err_cnt, saturating at 16'hFFFF; start and reset SHALL clear rb_err_cnt.
REQ-036 Without WB_STREAM_READBACK_EN, the READ state and the rb_err_cnt port SHALL be absent, and the block SHALL issue writes only.

Structure
REQ-037 Package wb_stream_pkg SHALL hold the state enum and the CTI_CLASSIC=3'b000 and BTE_LINEAR=2'b00 constants.
REQ-038 Sub-module stream_fifo SHALL be a synchronous FIFO parameterised by width and depth, with full, empty, push and pop ports.

Verification
REQ-039 Scenario: NWORDS=4, start, stream 32'h11,22,33,44 -> writes at adr 0,4,8,C with sel F, then done=1 for one cycle and word_cnt=4.
REQ-040 Scenario: s_valid gapped every other cycle -> stb low while the FIFO is empty, data order preserved, no duplicate writes.
REQ-041 Scenario: rty asserted once on word 2 -> the same adr 8 and data are reissued after a 1-cycle stb gap, with a total of 4 acks.
REQ-042 Scenario: err asserted on word 1 -> bus_err=1, done pulse, word_cnt=1, then IDLE.
REQ-043 Scenario: reset asserted while stb=1 on word 3 -> the next cycle has cyc=0, busy=0 and an empty FIFO.
REQ-044 Scenario with WB_STREAM_READBACK_EN, slave forced to return 32'hDEAD on the read of word 0 -> rb_err_cnt=1 and all 4 words are still written.
